data_mem_ctrl: RTL and testbench

//  Byte-lane data memory with a multi-cycle request/response handshake for the RV32I core.

---
 rtl/data_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-lane data memory with a request/response handshake.
// A store or load is latched in IDLE, waits Latency cycles in WAIT, touches
// the array on the last WAIT cycle and answers with a one-cycle pulse in DONE.
// Optional build macro: DMEM_RANGE_CHECK_EN. When it is defined, an address
// with nonzero bits above the word index raises err, suppresses the store and
// makes a load return zero. Without it, upper address bits wrap modulo Depth.
module data_mem_ctrl #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int Depth     = 1024,
    parameter int Latency   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_en,
    input  logic                 Load,
    input  logic [AddrWidth-1:0] addr,
    input  logic [3:0]           masking,
    input  logic [DataWidth-1:0] data_i,
    output logic                 busy,
    output logic                 data_valid,
    output logic                 store_done,
    output logic [DataWidth-1:0] rdata,
    output logic                 err
);

    localparam int         IdxWidth = $clog2(Depth);
    localparam int         Lanes    = DataWidth / 8;
    localparam logic [3:0] CntInit  = 4'(Latency - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  op_store_reg, op_store_next;
    logic [IdxWidth-1:0]   idx_reg, idx_next;
    logic [3:0]            mask_reg, mask_next;
    logic [DataWidth-1:0]  wdata_reg, wdata_next;
    logic                  range_err_reg, range_err_next;

    logic                  access;
    logic                  do_write;
    logic                  do_read;
    logic                  addr_out_of_range;

    // Address bits [1:0] select a byte inside the word and play no part here.
    logic                  unused_addr;
    assign unused_addr = ^{1'b0, addr};

`ifdef DMEM_RANGE_CHECK_EN
    assign addr_out_of_range = |(addr >> (IdxWidth + 2));
`else
    assign addr_out_of_range = 1'b0;
`endif

    // State and request-capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            op_store_reg  <= 1'b0;
            idx_reg       <= '0;
            mask_reg      <= 4'd0;
            wdata_reg     <= '0;
            range_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_store_reg  <= op_store_next;
            idx_reg       <= idx_next;
            mask_reg      <= mask_next;
            wdata_reg     <= wdata_next;
            range_err_reg <= range_err_next;
        end
    end

    // Next-state logic: accept in IDLE (store beats load), count down in WAIT.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_store_next  = op_store_reg;
        idx_next       = idx_reg;
        mask_next      = mask_reg;
        wdata_next     = wdata_reg;
        range_err_next = range_err_reg;
        access         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_en || Load) begin
                    op_store_next  = mem_en;
                    idx_next       = addr[IdxWidth+1:2];
                    mask_next      = masking;
                    wdata_next     = data_i;
                    range_err_next = addr_out_of_range;
                    cnt_next       = CntInit;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset in the access cycle must cancel the access, so rst gates both strobes.
    assign do_write = access && op_store_reg && !range_err_reg && !rst;
    assign do_read  = access && !op_store_reg && !rst;

    // One narrow RAM per byte lane so each mask bit is a plain write enable.
    generate
        for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
            logic [7:0] lane_mem [Depth];
            logic [7:0] lane_q_reg;

            // Lane write: only when this lane's mask bit is set.
            always_ff @(posedge clk) begin
                if (do_write && mask_reg[gi]) begin
                    lane_mem[idx_reg] <= wdata_reg[8*gi +: 8];
                end
            end

            // Registered lane read; holds its value until the next load.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_q_reg <= 8'h00;
                end else if (do_read) begin
                    lane_q_reg <= range_err_reg ? 8'h00 : lane_mem[idx_reg];
                end
            end

            assign rdata[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

    assign busy       = (state_reg != IDLE);
    assign data_valid = (state_reg == DONE) && !op_store_reg;
    assign store_done = (state_reg == DONE) && op_store_reg;

`ifdef DMEM_RANGE_CHECK_EN
    assign err = (state_reg == DONE) && range_err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl (Latency=2, Depth=1024).
// Expectations follow DMEM_RANGE_CHECK_EN the same way the design does.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic        Load;
    logic [31:0] addr;
    logic [3:0]  masking;
    logic [31:0] data_i;
    logic        busy;
    logic        data_valid;
    logic        store_done;
    logic [31:0] rdata;
    logic        err;

    int total_cnt = 0;
    int bad_cnt   = 0;

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic        RangeErr   = 1'b1;
    localparam logic [31:0] Word0After = 32'h01020304;
    localparam logic [31:0] HighLoad   = 32'h00000000;
`else
    localparam logic        RangeErr   = 1'b0;
    localparam logic [31:0] Word0After = 32'h77777777;
    localparam logic [31:0] HighLoad   = 32'h77777777;
`endif

    data_mem_ctrl #(
        .DataWidth(32),
        .AddrWidth(32),
        .Depth    (1024),
        .Latency  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_en    (mem_en),
        .Load      (Load),
        .addr      (addr),
        .masking   (masking),
        .data_i    (data_i),
        .busy      (busy),
        .data_valid(data_valid),
        .store_done(store_done),
        .rdata     (rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                            input logic exp_err, input string tag);
        int   lat;
        logic e;
        lat = 0;
        e   = 1'b0;
        @(negedge clk);
        addr = a; masking = m; data_i = d; mem_en = 1'b1;
        @(posedge clk);
        #1 mem_en = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (store_done) begin
                lat = c;
                e   = err;
                break;
            end
        end
        $display("store %s addr=%h mask=%b data=%h lat=%0d err=%0d", tag, a, m, d, lat, e);
        check_val({tag, "_lat"}, lat, 32'd3);
        check_val({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp_data,
                           input logic exp_err, input string tag);
        int          lat;
        logic        e;
        logic [31:0] q;
        lat = 0;
        e   = 1'b0;
        q   = 32'hx;
        @(negedge clk);
        addr = a; Load = 1'b1;
        @(posedge clk);
        #1 Load = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (data_valid) begin
                lat = c;
                e   = err;
                q   = rdata;
                break;
            end
        end
        $display("load  %s addr=%h rdata=%h lat=%0d err=%0d", tag, a, q, lat, e);
        check_val({tag, "_lat"}, lat, 32'd3);
        check_val({tag, "_data"}, q, exp_data);
        check_val({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    initial begin
        int n_dv;
        int n_sd;
        int first_dv;
        int second_dv;

        rst = 1'b1; mem_en = 1'b0; Load = 1'b0;
        addr = 32'd0; masking = 4'd0; data_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_flags", {28'd0, busy, data_valid, store_done, err}, 32'd0);
        check_val("reset_rdata", rdata, 32'd0);
        $display("reset released");
        rst = 1'b0;

        // T1: full-word store then load
        do_store(32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, "t1_st");
        do_load(32'h10, 32'hDEADBEEF, 1'b0, "t1_ld");

        // T2: single-byte merge, plus an all-zero mask store
        do_store(32'h20, 4'b1111, 32'h11223344, 1'b0, "t2_full");
        do_store(32'h20, 4'b0100, 32'h00AA0000, 1'b0, "t2_byte");
        check_val("rdata_held", rdata, 32'hDEADBEEF);
        do_load(32'h20, 32'h11AA3344, 1'b0, "t2_ld");
        do_store(32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0, "t2_mask0");
        do_load(32'h20, 32'h11AA3344, 1'b0, "t2_ld0");

        // T3: Load held across busy; second request accepted in cycle 4
        n_dv = 0; first_dv = 0; second_dv = 0;
        @(negedge clk);
        addr = 32'h10; Load = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (data_valid) begin
                n_dv++;
                if (n_dv == 1) first_dv = c;
                else if (n_dv == 2) second_dv = c;
            end
            if (c == 5) begin
                check_val("t3_busy_c5", {31'd0, busy}, 32'd1);
                Load = 1'b0;
            end
        end
        $display("held load pulses=%0d first=%0d second=%0d", n_dv, first_dv, second_dv);
        check_val("t3_pulses", n_dv, 32'd2);
        check_val("t3_first", first_dv, 32'd3);
        check_val("t3_second", second_dv, 32'd7);
        check_val("t3_rdata", rdata, 32'hDEADBEEF);

        // T4: store and load together -> store only
        do_store(32'h40, 4'b1111, 32'hCAFEF00D, 1'b0, "t4_init");
        n_dv = 0; n_sd = 0;
        @(negedge clk);
        addr = 32'h40; masking = 4'b0001; data_i = 32'h00000055;
        mem_en = 1'b1; Load = 1'b1;
        @(posedge clk);
        #1 mem_en = 1'b0; Load = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (data_valid) n_dv++;
            if (store_done) n_sd++;
        end
        $display("collision store_done=%0d data_valid=%0d", n_sd, n_dv);
        check_val("t4_sd", n_sd, 32'd1);
        check_val("t4_dv", n_dv, 32'd0);
        check_val("t4_rdata_kept", rdata, 32'hDEADBEEF);
        do_load(32'h40, 32'hCAFEF055, 1'b0, "t4_ld");

        // T5a: reset in WAIT cycle 1 aborts the store
        do_store(32'h30, 4'b1111, 32'h00000000, 1'b0, "t5_init");
        n_sd = 0;
        @(negedge clk);
        addr = 32'h30; masking = 4'b1111; data_i = 32'hFFFFFFFF; mem_en = 1'b1;
        @(posedge clk);
        #1 mem_en = 1'b0;
        @(negedge clk);
        check_val("t5_busy_c1", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("t5_rst_flags", {28'd0, busy, data_valid, store_done, err}, 32'd0);
        check_val("t5_rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (store_done) n_sd++;
        end
        $display("reset in wait store_done=%0d", n_sd);
        check_val("t5_no_sd", n_sd, 32'd0);
        do_load(32'h30, 32'h00000000, 1'b0, "t5_ld");

        // T5b: reset in the access cycle blocks the write
        n_sd = 0;
        @(negedge clk);
        addr = 32'h30; masking = 4'b1111; data_i = 32'h12345678; mem_en = 1'b1;
        @(posedge clk);
        #1 mem_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (store_done) n_sd++;
        end
        $display("reset at access store_done=%0d", n_sd);
        check_val("t5b_no_sd", n_sd, 32'd0);
        do_load(32'h30, 32'h00000000, 1'b0, "t5b_ld");

        // T6: address above the 1024-word range
        do_store(32'h0, 4'b1111, 32'h01020304, 1'b0, "t6_init");
        do_store(32'h1000, 4'b1111, 32'h77777777, RangeErr, "t6_st");
        do_load(32'h0, Word0After, 1'b0, "t6_ld0");
        do_load(32'h1000, HighLoad, RangeErr, "t6_ldhi");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
